rv32_ctrl_pipe: RTL and testbench
=================================

# rv32_ctrl_pipe

Pipelined control unit for the 3-stage RV32 datapath: decodes the fetched instruction and produces the 13-bit `ctrl` word that the datapath consumes. Stage-aligned control bundles for Fetch/Decode (FD), Execute (EX) and Memory/WriteBack (MW) are held here. Branches are resolved from the ALU result, with a single-bubble flush on a taken branch. RAW hazards stall the pipeline, because the datapath has no forwarding.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `inst`  input  32  instruction currently in FD, from imem.
- `alu_res`  input  32  datapath ALU result for the instruction in EX.
- `ctrl`  output  [0:12]  datapath control word; bit 0 is MSB.
- `pc_en`  output  1  1 = PC and imem may advance; 0 = hold (stall).
- `illegal`  output  1  sticky flag; set when an unsupported opcode is decoded in FD.

## Operation
- ctrl field map:
  - [0] pc_sel, 1 = branch target.
  - [1] reg write enable.
  - [2:4] reserved, always 0.
  - [5] immgen form: 0 = I-type, 1 = S/B-type.
  - [6] ALU src: 1 = immediate.
  - [7:10] ALU op.
  - [11] dmem write.
  - [12] writeback select: 1 = dmem data.
- Field source stage:
  - [5] comes combinationally from FD `inst`.
  - [0] and [6:10] come from the EX register; [0] is also qualified by `alu_res`.
  - [1], [11] and [12] come from the MW register.
- Supported instructions:
  - R-type (opcode 0110011): ALU op = {funct7[5], funct3}; regwrite=1; src=0.
  - I-ALU (0010011): ALU op = {0, funct3}, except SRAI, which uses 1101; src=1; imm=0; regwrite=1.
  - LW (0000011, funct3 010): op 0000; src=1; imm=0; regwrite=1; wbsel=1.
  - SW (0100011, funct3 010): op 0000; src=1; imm=1; memwrite=1.
  - BEQ/BNE (1100011, funct3 000/001): op 1000 (SUB); src=0; imm=1; branch flag and polarity are carried to EX.
- Any other opcode/funct3 decodes as a bubble (all ctrl fields 0) and sets `illegal`.
- Bubble: all stage fields 0; rd=0.
- Branch resolution in EX:
  - taken = BEQ & (alu_res==0), or BNE & (alu_res!=0).
  - When taken, ctrl[0]=1 in that cycle, and the next EX register load is forced to a bubble (flush of the FD instruction).
- RAW stall:
  - Condition: the FD instruction reads rs1 or rs2 (nonzero, and used by its format), and that register equals the rd of an EX or MW instruction with regwrite=1 and rd≠0.
  - Response: pc_en=0, EX loads a bubble, FD holds.
- Priority: a taken-branch flush overrides a stall. pc_en=1 when a flush occurs.
- rd=x0 writes never cause a stall. Their regwrite is still driven as decoded; the register file discards the write.

## Timing
- Reset (asynchronous assert, synchronous release):
  - EX and MW registers hold bubbles.
  - illegal=0; pc_en=1.
  - ctrl = 0 except ctrl[5], which follows `inst`.
- Latency: an instruction decoded in FD at cycle N has its EX fields on `ctrl` at N+1 and its MW fields at N+2.
- pc_en and ctrl[0] are combinational within the cycle; all stage registers update on posedge clk.
- `illegal` sets on the clock edge after the illegal FD decode and clears only on reset.
- Reset mid-stall or mid-flush: all state returns to bubble immediately.

## Test plan
- Reset with inst=0x00000013 (NOP):
  - required: ctrl=0, pc_en=1, illegal=0.
  - after release, NOP flows with ctrl[1]=1 and rd=0, and never stalls.
- ADD x3,x1,x2 (0x002081B3), then SUB x3,x1,x2 (0x402081B3):
  - ADD in EX: ctrl[6:10]=0_0000.
  - SUB in EX, next cycle: ctrl[6:10]=0_1000.
  - each instruction's MW cycle: ctrl[1]=1, ctrl[12]=0.
- LW x5,0(x1) (0x0000A283), then ADD x6,x5,x5:
  - pc_en=0 for 2 cycles, with bubbles inserted in EX.
  - LW's MW cycle: ctrl[1]=1, ctrl[12]=1.
  - ADD proceeds afterwards.
- SW x2,4(x1) (0x0020A223) in FD:
  - FD cycle: ctrl[5]=1.
  - EX cycle: ctrl[6]=1.
  - MW cycle: ctrl[11]=1, ctrl[1]=0.
- BEQ x1,x2,+8 (0x00208463) in EX:
  - alu_res=0: ctrl[0]=1, and the following EX slot is a bubble.
  - alu_res=5: ctrl[0]=0, and no flush occurs.
  - repeat with a stall-causing FD instruction: the flush wins and pc_en=1.
- inst=0x00000000:
  - illegal=1 after the next edge, and the EX slot is a bubble.
  - illegal stays 1 through later valid instructions, and clears on rst_n=0.

Source files
------------

// File: rtl/rv32_ctrl_pipe.sv
// rv32_ctrl_pipe: decodes FD instruction and drives the stage-aligned ctrl word for the 3-stage RV32 datapath
module rv32_ctrl_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] alu_res,
  output logic [0:12] ctrl,
  output logic        pc_en,
  output logic        illegal
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, d_rd;
  logic is_r, is_i, is_lw, is_sw, is_br, legal;
  logic d_rw, d_imm, d_src, d_rs2;
  logic [3:0] d_op;
  logic ex_src, ex_br, ex_bne, ex_rw, ex_mw, ex_wb;
  logic [3:0] ex_op;
  logic [4:0] ex_rd;
  logic mw_rw, mw_mw, mw_wb;
  logic [4:0] mw_rd;
  logic h1, h2, taken, stall, kill;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign is_r  = opc == 7'b0110011;
  assign is_i  = opc == 7'b0010011;
  assign is_lw = opc == 7'b0000011 && f3 == 3'b010;
  assign is_sw = opc == 7'b0100011 && f3 == 3'b010;
  assign is_br = opc == 7'b1100011 && f3[2:1] == 2'b00;
  assign legal = is_r | is_i | is_lw | is_sw | is_br;
  assign d_rw  = is_r | is_i | is_lw;
  assign d_imm = is_sw | is_br;
  assign d_src = is_i | is_lw | is_sw;
  assign d_rs2 = is_r | is_sw | is_br;
  assign d_rd  = d_rw ? inst[11:7] : 5'd0;
  // only SRAI among the immediate shifts carries funct7[5] into the op
  assign d_op  = is_r ? {inst[30], f3} :
                 is_i ? {inst[30] & (f3 == 3'b101), f3} :
                 is_br ? 4'b1000 : 4'b0000;
  assign h1 = rs1 != 5'd0 && ((ex_rw && ex_rd == rs1) || (mw_rw && mw_rd == rs1));
  assign h2 = rs2 != 5'd0 && ((ex_rw && ex_rd == rs2) || (mw_rw && mw_rd == rs2));
  assign taken = ex_br & (ex_bne ? alu_res != 32'd0 : alu_res == 32'd0);
  assign stall = !taken & ((legal & h1) | (d_rs2 & h2));
  assign kill  = taken | stall | !legal;
  assign pc_en = !stall;
  assign ctrl  = {taken, mw_rw, 3'b000, d_imm, ex_src, ex_op, mw_mw, mw_wb};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ex_src, ex_br, ex_bne, ex_rw, ex_mw, ex_wb, ex_op, ex_rd} <= '0;
      {mw_rw, mw_mw, mw_wb, mw_rd} <= '0;
      illegal <= 1'b0;
    end else begin
      ex_src  <= !kill & d_src;
      ex_br   <= !kill & is_br;
      ex_bne  <= !kill & is_br & f3[0];
      ex_rw   <= !kill & d_rw;
      ex_mw   <= !kill & is_sw;
      ex_wb   <= !kill & is_lw;
      ex_op   <= kill ? 4'd0 : d_op;
      ex_rd   <= kill ? 5'd0 : d_rd;
      mw_rw   <= ex_rw;
      mw_mw   <= ex_mw;
      mw_wb   <= ex_wb;
      mw_rd   <= ex_rd;
      illegal <= illegal | !legal;
    end
  end
endmodule

// File: tb/tb_rv32_ctrl_pipe.sv
// tb_rv32_ctrl_pipe: instruction-word pipeline model plus directed vectors for rv32_ctrl_pipe
module tb_rv32_ctrl_pipe;
  logic clk = 0, rst_n = 0;
  logic [31:0] inst = 32'h13, alu_res = 0;
  logic [0:12] ctrl;
  logic pc_en, illegal;
  int total = 0, bad = 0;

  rv32_ctrl_pipe dut (.clk(clk), .rst_n(rst_n), .inst(inst), .alu_res(alu_res),
                      .ctrl(ctrl), .pc_en(pc_en), .illegal(illegal));

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h00000013, ADD = 32'h002081B3, SUB = 32'h402081B3,
    LW = 32'h0000A283, ADD655 = 32'h00528333, SW = 32'h0020A223, BEQ = 32'h00208463,
    ADDI7 = 32'h00100393, ADD877 = 32'h00738433;

  typedef struct packed {
    logic legal, rw, imm, src;
    logic [3:0] op;
    logic mw, wb, br, bne;
    logic [4:0] rd, r1, r2;
  } dec_t;

  // what each instruction means by the field table; registers not read are reported as x0
  function automatic dec_t dec(input logic [31:0] i);
    dec_t d;
    d = '0;
    case (i[6:0])
      7'b0110011: begin
        d.legal = 1; d.rw = 1; d.op = {i[30], i[14:12]};
        d.rd = i[11:7]; d.r1 = i[19:15]; d.r2 = i[24:20];
      end
      7'b0010011: begin
        d.legal = 1; d.rw = 1; d.src = 1; d.rd = i[11:7]; d.r1 = i[19:15];
        d.op = (i[14:12] == 3'd5 && i[30]) ? 4'b1101 : {1'b0, i[14:12]};
      end
      7'b0000011: if (i[14:12] == 3'd2) begin
        d.legal = 1; d.rw = 1; d.src = 1; d.wb = 1; d.rd = i[11:7]; d.r1 = i[19:15];
      end
      7'b0100011: if (i[14:12] == 3'd2) begin
        d.legal = 1; d.imm = 1; d.src = 1; d.mw = 1; d.r1 = i[19:15]; d.r2 = i[24:20];
      end
      7'b1100011: if (i[14:12] <= 3'd1) begin
        d.legal = 1; d.imm = 1; d.br = 1; d.bne = i[12]; d.op = 4'b1000;
        d.r1 = i[19:15]; d.r2 = i[24:20];
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // model state: raw instruction words in EX and MW (0 = bubble, it decodes to all-zero)
  logic [31:0] m_ex, m_mw;
  logic m_ill;
  dec_t f, e, w;
  logic m_taken, m_haz;
  logic [0:12] exp_ctrl;

  always_comb begin
    f = dec(inst);
    e = dec(m_ex);
    w = dec(m_mw);
    m_taken = e.br && (e.bne ? alu_res != 0 : alu_res == 0);
    m_haz = 0;
    if (f.r1 != 0 && ((e.rw && e.rd == f.r1) || (w.rw && w.rd == f.r1))) m_haz = 1;
    if (f.r2 != 0 && ((e.rw && e.rd == f.r2) || (w.rw && w.rd == f.r2))) m_haz = 1;
    exp_ctrl = {m_taken, w.rw, 3'b000, f.imm, e.src, e.op, w.mw, w.wb};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex = 0; m_mw = 0; m_ill = 0;
    end else begin
      m_mw = m_ex;
      m_ex = (m_taken || m_haz) ? 32'd0 : inst;
      m_ill = m_ill | !f.legal;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model ctrl", 32'(ctrl), 32'(exp_ctrl));
    chk("model pc_en", 32'(pc_en), 32'(m_taken || !m_haz));
    chk("model illegal", 32'(illegal), 32'(m_ill));
  end

  task automatic tick(input logic [31:0] i, input logic [31:0] a = 0);
    @(posedge clk);
    #1;
    inst = i;
    alu_res = a;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(NOP); tick(NOP);
    chk("reset ctrl", 32'(ctrl), 0);
    chk("reset pc_en", 32'(pc_en), 1);
    chk("reset illegal", 32'(illegal), 0);
    @(posedge clk); #1 rst_n = 1;
    tick(NOP); tick(NOP);
    chk("nop steady ctrl", 32'(ctrl), 32'h0840);
    chk("nop pc_en", 32'(pc_en), 1);
    tick(ADD);
    tick(SUB);
    chk("add ex op", 32'(ctrl[6:10]), 5'b00000);
    chk("sub no stall", 32'(pc_en), 1);
    tick(NOP);
    chk("sub ex op", 32'(ctrl[6:10]), 5'b01000);
    chk("add mw rw", 32'(ctrl[1]), 1);
    chk("add mw wb", 32'(ctrl[12]), 0);
    tick(NOP);
    chk("sub mw rw", 32'(ctrl[1]), 1);
    tick(NOP); tick(NOP);
    tick(LW);
    tick(ADD655);
    chk("lw stall 1", 32'(pc_en), 0);
    tick(ADD655);
    chk("lw stall 2", 32'(pc_en), 0);
    chk("lw mw rw", 32'(ctrl[1]), 1);
    chk("lw mw wb", 32'(ctrl[12]), 1);
    chk("stall bubble ex", 32'(ctrl[6:10]), 0);
    tick(ADD655);
    chk("add proceeds", 32'(pc_en), 1);
    tick(NOP);
    chk("bubble in mw", 32'(ctrl[1]), 0);
    tick(NOP);
    chk("add6 mw rw", 32'(ctrl[1]), 1);
    tick(SW);
    chk("sw fd imm", 32'(ctrl[5]), 1);
    tick(NOP);
    chk("sw ex src", 32'(ctrl[6]), 1);
    tick(NOP);
    chk("sw mw memwrite", 32'(ctrl[11]), 1);
    chk("sw mw rw", 32'(ctrl[1]), 0);
    tick(BEQ);
    tick(ADDI7, 0);
    chk("beq taken", 32'(ctrl[0]), 1);
    chk("beq ex op", 32'(ctrl[7:10]), 4'b1000);
    tick(NOP);
    chk("flush bubble src", 32'(ctrl[6]), 0);
    chk("flush pc_sel clear", 32'(ctrl[0]), 0);
    tick(BEQ);
    tick(ADDI7, 5);
    chk("beq not taken", 32'(ctrl[0]), 0);
    tick(NOP);
    chk("addi not flushed", 32'(ctrl[6]), 1);
    tick(NOP); tick(NOP);
    tick(ADDI7);
    tick(BEQ);
    tick(ADD877, 5);
    chk("stall without flush", 32'(pc_en), 0);
    tick(NOP); tick(NOP); tick(NOP);
    tick(ADDI7);
    tick(BEQ);
    tick(ADD877, 0);
    chk("flush beats stall pc_en", 32'(pc_en), 1);
    chk("flush beats stall pc_sel", 32'(ctrl[0]), 1);
    tick(NOP);
    tick(32'h0);
    chk("illegal before edge", 32'(illegal), 0);
    tick(NOP);
    chk("illegal set", 32'(illegal), 1);
    chk("illegal ex bubble", 32'(ctrl[6:10]), 0);
    tick(ADD); tick(NOP);
    chk("illegal sticky", 32'(illegal), 1);
    tick(LW);
    tick(ADD655);
    #1 rst_n = 0;
    #1;
    chk("reset mid-stall illegal", 32'(illegal), 0);
    chk("reset mid-stall pc_en", 32'(pc_en), 1);
    chk("reset mid-stall ctrl", 32'(ctrl), 0);
    tick(NOP);
    @(posedge clk); #1 rst_n = 1;
    tick(NOP); tick(NOP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
